if_xact: RTL and testbench

- Master-side transaction sequencer for the system interface.
- Accepts one read, write or signal command from the CPU control logic and drives the four-phase request/answer handshake on the interface.
- Classifies the answer (OK / EN / PE) or, when no answer arrives, the no-answer alarm.
- Drives the alarm timer's engage input and consumes its talarm output.

---
 rtl/if_xact_pkg.sv | 34 +++
 rtl/if_xact_sync.sv | 21 ++
 rtl/if_xact.sv | 115 +++++++++++
 tb/tb_if_xact.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/if_xact_pkg.sv
// Shared encodings for the system-interface transaction sequencer.
package if_xact_pkg;

  // Command opcodes (3 is reserved and behaves as a signal command)
  localparam logic [1:0] OP_READ   = 2'd0;
  localparam logic [1:0] OP_WRITE  = 2'd1;
  localparam logic [1:0] OP_SIGNAL = 2'd2;
  localparam logic [1:0] OP_RSVD   = 2'd3;

  // Completion status codes
  localparam logic [1:0] ST_OK    = 2'd0;
  localparam logic [1:0] ST_EN    = 2'd1;
  localparam logic [1:0] ST_PE    = 2'd2;
  localparam logic [1:0] ST_ALARM = 2'd3;

  // Sequencer states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_REL  = 2'd2,
    S_DONE = 2'd3
  } if_state_e;

  // Answer classification: parity error beats not-ready beats ok.
  function automatic logic [1:0] classify(input logic ok, input logic en, input logic pe);
    logic [1:0] st;
    if (pe)      st = ST_PE;
    else if (en) st = ST_EN;
    else if (ok) st = ST_OK;
    else         st = ST_OK;
    return st;
  endfunction

endpackage

// File: rtl/if_xact_sync.sv
// N-stage synchroniser for one asynchronous answer line.
module if_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // Shift the asynchronous input through the flop chain
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/if_xact.sv
// Master-side transaction sequencer: one command in, four-phase
// request/answer handshake out, classified completion back.
//
// Handshake: a command is taken on a clk_sys edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only while idle, so the
// upstream simply holds cmd_valid until it is taken. rsp_done is a
// one-cycle pulse; rsp_status/rsp_rdata stay put until the next pulse.
module if_xact
  import if_xact_pkg::*;
#(
  parameter int AW          = 16,
  parameter int DW          = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic          cmd_valid,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          cmd_ready,
  output logic          rsp_done,
  output logic [1:0]    rsp_status,
  output logic [DW-1:0] rsp_rdata,
  output logic          bus_req,
  output logic [1:0]    bus_op,
  output logic [AW-1:0] bus_ad,
  output logic [DW-1:0] bus_dt,
  input  logic          bus_ok,
  input  logic          bus_en,
  input  logic          bus_pe,
  input  logic [DW-1:0] bus_rdata,
  output logic          engage,
  input  logic          talarm,
  output if_state_e     dbg_state
);

  if_state_e  state;
  logic       ok_s, en_s, pe_s;
  logic       ans;
  logic [1:0] st_q;

  if_sync #(.STAGES(SYNC_STAGES)) u_sync_ok (.clk_sys(clk_sys), .rst_n(rst_n), .d(bus_ok), .q(ok_s));
  if_sync #(.STAGES(SYNC_STAGES)) u_sync_en (.clk_sys(clk_sys), .rst_n(rst_n), .d(bus_en), .q(en_s));
  if_sync #(.STAGES(SYNC_STAGES)) u_sync_pe (.clk_sys(clk_sys), .rst_n(rst_n), .d(bus_pe), .q(pe_s));

  assign ans       = ok_s | en_s | pe_s;
  assign cmd_ready = (state == S_IDLE);
  assign dbg_state = state;

  // Sequencer FSM; every output it owns is registered here
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      st_q       <= ST_OK;
      bus_req    <= 1'b0;
      engage     <= 1'b0;
      rsp_done   <= 1'b0;
      rsp_status <= ST_OK;
      rsp_rdata  <= '0;
      bus_op     <= '0;
      bus_ad     <= '0;
      bus_dt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            bus_op  <= cmd_op;
            bus_ad  <= cmd_addr;
            bus_dt  <= cmd_wdata;
            bus_req <= 1'b1;
            engage  <= 1'b1;
            state   <= S_REQ;
          end
        end
        S_REQ: begin
          // An answer in the same cycle as the alarm takes precedence
          if (ans) begin
            st_q    <= classify(ok_s, en_s, pe_s);
            // bus_rdata is stable for as long as an answer line is high
            if (bus_op == OP_READ && ok_s && !en_s && !pe_s) rsp_rdata <= bus_rdata;
            bus_req <= 1'b0;
            state   <= S_REL;
          end else if (talarm) begin
            rsp_status <= ST_ALARM;
            bus_req    <= 1'b0;
            engage     <= 1'b0;
            rsp_done   <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_REL: begin
          // A line that never releases is caught by the alarm timer
          if (!ans) begin
            rsp_status <= st_q;
            engage     <= 1'b0;
            rsp_done   <= 1'b1;
            state      <= S_DONE;
          end else if (talarm) begin
            rsp_status <= ST_ALARM;
            engage     <= 1'b0;
            rsp_done   <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          rsp_done <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_xact.sv
// Randomised scoreboard bench for if_xact with a 20-cycle alarm timer model.
module tb_if_xact;
  import if_xact_pkg::*;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_addr, cmd_wdata;
  logic        cmd_ready, rsp_done;
  logic [1:0]  rsp_status;
  logic [15:0] rsp_rdata;
  logic        bus_req;
  logic [1:0]  bus_op;
  logic [15:0] bus_ad, bus_dt;
  logic        bus_ok, bus_en, bus_pe;
  logic [15:0] bus_rdata;
  logic        engage, talarm;
  if_state_e   dbg_state;

  int          total = 0;
  int          bad   = 0;
  logic [17:0] exp_q[$];
  logic [15:0] last_rdata = 16'h0;
  int          alarm_cnt;

  if_xact #(.AW(16), .DW(16), .SYNC_STAGES(2)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_ready(cmd_ready), .rsp_done(rsp_done), .rsp_status(rsp_status), .rsp_rdata(rsp_rdata),
    .bus_req(bus_req), .bus_op(bus_op), .bus_ad(bus_ad), .bus_dt(bus_dt),
    .bus_ok(bus_ok), .bus_en(bus_en), .bus_pe(bus_pe), .bus_rdata(bus_rdata),
    .engage(engage), .talarm(talarm), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk_sys = ~clk_sys;

  // Alarm timer model: one-cycle talarm after 20 consecutive engaged cycles
  always @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      alarm_cnt <= 0;
      talarm    <= 1'b0;
    end else if (engage) begin
      alarm_cnt <= alarm_cnt + 1;
      talarm    <= (alarm_cnt + 1 == 20);
    end else begin
      alarm_cnt <= 0;
      talarm    <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every completion pulse must match the oldest expectation
  always @(negedge clk_sys) begin
    if (rst_n && rsp_done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done: got rsp_done=1 expected no completion at %0t", $time);
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        chk("rsp_status", {30'd0, rsp_status}, {30'd0, e[17:16]});
        chk("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, e[15:0]});
      end
    end
  end

  // Driver: present one command (called at a negedge, returns at a negedge)
  task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] wd);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk_sys);
      n++;
    end
    chk("issue_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = wd;
    @(posedge clk_sys); #1;
    cmd_valid = 1'b0;
    chk("req_rise", {31'd0, bus_req}, 32'd1);
    chk("bus_op", {30'd0, bus_op}, {30'd0, op});
    chk("bus_ad", {16'd0, bus_ad}, {16'd0, a});
    chk("bus_dt", {16'd0, bus_dt}, {16'd0, wd});
    @(negedge clk_sys);
  endtask

  // Wait for a DUT output condition, counting rising edges (bounded)
  task automatic wait_req_low(input int limit, output int n);
    n = 0;
    do begin @(posedge clk_sys); #1; n++; end while (bus_req && n < limit);
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    do begin @(posedge clk_sys); #1; n++; end while (!rsp_done && n < limit);
  endtask

  // Full transaction: reference outcome pushed first, then bus is driven
  task automatic run_xact(input logic [1:0] op, input logic [15:0] a, input logic [15:0] wd,
                          input logic ok, input logic en, input logic pe,
                          input logic [15:0] rd, input int d, input int h);
    logic [1:0] st;
    int n;
    if (!(ok | en | pe)) st = 2'd3;
    else if (pe)         st = 2'd2;
    else if (en)         st = 2'd1;
    else                 st = 2'd0;
    if (op == 2'd0 && st == 2'd0) last_rdata = rd;
    exp_q.push_back({st, last_rdata});
    issue(op, a, wd);
    if (ok | en | pe) begin
      repeat (d) @(negedge clk_sys);
      bus_ok = ok; bus_en = en; bus_pe = pe; bus_rdata = rd;
      wait_req_low(40, n);
      chk("req_drop_lat", n, 3);
      chk("rel_engage", {31'd0, engage}, 32'd1);
      repeat (h) @(negedge clk_sys);
      bus_ok = 1'b0; bus_en = 1'b0; bus_pe = 1'b0; bus_rdata = 16'($urandom);
      wait_done(40, n);
      chk("done_lat", n, 3);
    end else begin
      wait_req_low(60, n);
      chk("alarm_req_drop", n, 21);
      chk("alarm_done", {31'd0, rsp_done}, 32'd1);
    end
    chk("done_engage", {31'd0, engage}, 32'd0);
    chk("done_ready", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk_sys); #1;
    chk("post_ready", {31'd0, cmd_ready}, 32'd1);
    chk("post_done", {31'd0, rsp_done}, 32'd0);
    @(negedge clk_sys);
  endtask

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    int n;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = 16'h0; cmd_wdata = 16'h0;
    bus_ok = 1'b0; bus_en = 1'b0; bus_pe = 1'b0; bus_rdata = 16'h0;
    repeat (3) @(negedge clk_sys);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_req", {31'd0, bus_req}, 32'd0);
    chk("rst_engage", {31'd0, engage}, 32'd0);
    chk("rst_done", {31'd0, rsp_done}, 32'd0);
    chk("rst_status", {30'd0, rsp_status}, 32'd0);
    chk("rst_rdata", {16'd0, rsp_rdata}, 32'd0);
    chk("rst_ad", {16'd0, bus_ad}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk_sys);

    // Directed cases
    run_xact(2'd1, 16'h1234, 16'hBEEF, 1'b1, 1'b0, 1'b0, 16'h0000, 5, 4);
    run_xact(2'd0, 16'h0010, 16'h0000, 1'b1, 1'b0, 1'b0, 16'hA5A5, 2, 2);
    chk("read_ok_rdata", {16'd0, rsp_rdata}, 32'hA5A5);
    run_xact(2'd0, 16'h0010, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h5A5A, 2, 2);
    chk("read_en_rdata", {16'd0, rsp_rdata}, 32'hA5A5);
    run_xact(2'd0, 16'h0020, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h1111, 1, 1);

    // No answer: alarm, then a late answer while idle is ignored
    run_xact(2'd2, 16'h0030, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 0);
    repeat (3) @(negedge clk_sys);
    bus_ok = 1'b1;
    repeat (4) @(negedge clk_sys);
    bus_ok = 1'b0;
    repeat (6) @(negedge clk_sys);
    chk("late_ok_status", {30'd0, rsp_status}, 32'd3);
    chk("late_ok_ready", {31'd0, cmd_ready}, 32'd1);

    // Hung answer line: alarm in release phase, then recovery
    exp_q.push_back({2'd3, last_rdata});
    issue(2'd1, 16'h0BAD, 16'h1111);
    repeat (2) @(negedge clk_sys);
    bus_ok = 1'b1;
    wait_done(80, n);
    chk("hung_done", {31'd0, rsp_done}, 32'd1);
    chk("hung_req", {31'd0, bus_req}, 32'd0);
    @(negedge clk_sys);
    @(negedge clk_sys);
    exp_q.push_back({2'd0, last_rdata});
    issue(2'd2, 16'h0BEE, 16'h2222);
    wait_req_low(20, n);
    chk("hung_next_req_drop", n, 1);
    repeat (3) @(negedge clk_sys);
    bus_ok = 1'b0;
    wait_done(40, n);
    chk("hung_next_done_lat", n, 3);
    @(negedge clk_sys);
    @(negedge clk_sys);

    // Reset in the middle of a request
    issue(2'd0, 16'h0044, 16'h0000);
    repeat (2) @(negedge clk_sys);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_req", {31'd0, bus_req}, 32'd0);
    chk("midrst_engage", {31'd0, engage}, 32'd0);
    chk("midrst_done", {31'd0, rsp_done}, 32'd0);
    last_rdata = 16'h0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    rst_n = 1'b1;
    @(posedge clk_sys); #1;
    chk("midrst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("midrst_status", {30'd0, rsp_status}, 32'd0);
    repeat (5) @(negedge clk_sys);

    // Randomised traffic
    for (int i = 0; i < 40; i++) begin
      logic [2:0] ans;
      ans = ($urandom_range(0, 7) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
      run_xact(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
               ans[0], ans[1], ans[2], 16'($urandom),
               $urandom_range(0, 5), $urandom_range(1, 4));
      repeat ($urandom_range(0, 2)) @(negedge clk_sys);
    end

    repeat (4) @(negedge clk_sys);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
